// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared types and constants for the UDP payload packer
package udp_pkg;

   typedef logic [15:0] udp_len_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      STREAM,
      DONE
   } udp_state_t;

   // Smallest payload that still fills a 64-byte Ethernet frame
   localparam udp_len_t UDP_MIN_PAYLOAD = 16'd18;

endpackage

// File: rtl/udp_len_fifo.sv
// rtl/udp_len_fifo.sv - queue of committed packet lengths awaiting the framer
module udp_len_fifo
   import udp_pkg::*;
#(
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [15:0]   push_data,
   input  logic          pop,
   output logic [15:0]   head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   udp_len_t    mem [2**AW];

   assign count = wptr - rptr;
   assign full  = (count == {1'b1, {AW{1'b0}}});
   assign empty = (wptr == rptr);
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/udp_payload_packer.sv
// rtl/udp_payload_packer.sv - packet byte buffer feeding the UDP transmit framer
// Optional UDP_PAD_EN: pad short payloads with zeros up to UDP_MIN_PAYLOAD.
module udp_payload_packer
   import udp_pkg::*;
#(
   parameter int ADDR_W  = 11,
   parameter int LQ_AW   = 3,
   parameter int MAX_LEN = 1472
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       i_wr_data,
   input  logic             i_wr_en,
   input  logic             i_wr_last,
   output logic             o_wr_ready,
   output logic             o_drop,
   output logic [LQ_AW:0]   o_pkt_cnt,
   input  logic             i_ready,
   output logic             o_enable,
   output logic [15:0]      o_data_len,
   input  logic             i_rd,
   output logic [7:0]       o_rd_data
);

   localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
   localparam udp_len_t        MAX_LEN_L = 16'(MAX_LEN);

   logic [7:0]      mem [2**ADDR_W];
   logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr, rd_ptr_nxt;
   udp_len_t        wr_cnt, seg_len, stored_len, idx, idx_nxt, lq_head, pkt_len;
   udp_state_t      state;
   logic            discard, ram_full, lq_full, lq_empty, lq_push, lq_pop;
   logic            byte_ok, seg_end, overflow, rd_fire;

   assign ram_full   = ((wr_ptr - rd_ptr) == {1'b1, {ADDR_W{1'b0}}});
   assign o_wr_ready = !ram_full && !lq_full;

   assign seg_len  = wr_cnt + 16'd1;
   assign byte_ok  = i_wr_en && !discard && !ram_full;
   assign seg_end  = i_wr_last || (seg_len == MAX_LEN_L);
   assign overflow = i_wr_en && !discard && (ram_full || (seg_end && lq_full));
   assign lq_push  = byte_ok && seg_end && !lq_full;

   // A rewind on overflow drops only the uncommitted tail; committed packets survive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         wr_cnt     <= '0;
         discard    <= 1'b0;
         o_drop     <= 1'b0;
      end else begin
         o_drop <= overflow;
         if (i_wr_en && discard) begin
            if (i_wr_last) discard <= 1'b0;
         end else if (overflow) begin
            wr_ptr  <= commit_ptr;
            wr_cnt  <= '0;
            discard <= !i_wr_last;
         end else if (byte_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (seg_end) begin
               commit_ptr <= wr_ptr + PTR_ONE;
               wr_cnt     <= '0;
            end else begin
               wr_cnt <= seg_len;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (byte_ok) mem[wr_ptr[ADDR_W-1:0]] <= i_wr_data;
   end

   udp_len_fifo #(.AW(LQ_AW)) u_len_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lq_push),
      .push_data (seg_len),
      .pop       (lq_pop),
      .head      (lq_head),
      .count     (o_pkt_cnt),
      .full      (lq_full),
      .empty     (lq_empty)
   );

`ifdef UDP_PAD_EN
   assign pkt_len = (lq_head < UDP_MIN_PAYLOAD) ? UDP_MIN_PAYLOAD : lq_head;
`else
   assign pkt_len = lq_head;
`endif

   assign rd_fire    = (state == STREAM) && i_rd;
   assign idx_nxt    = rd_fire ? idx + 16'd1 : idx;
   assign rd_ptr_nxt = (rd_fire && (idx < stored_len)) ? rd_ptr + PTR_ONE : rd_ptr;
   assign lq_pop     = rd_fire && (idx_nxt == o_data_len);

   // o_rd_data is show-ahead: it always holds the byte the next i_rd will consume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         o_enable   <= 1'b0;
         o_data_len <= '0;
         o_rd_data  <= '0;
         stored_len <= '0;
         idx        <= '0;
         rd_ptr     <= '0;
      end else begin
         o_enable  <= 1'b0;
         rd_ptr    <= rd_ptr_nxt;
         idx       <= idx_nxt;
         o_rd_data <= ((state == WAIT_BUSY || state == STREAM) && (idx_nxt < stored_len))
                      ? mem[rd_ptr_nxt[ADDR_W-1:0]] : 8'h00;
         case (state)
            IDLE:      if (!lq_empty && i_ready) state <= START;
            START: begin
               o_enable   <= 1'b1;
               o_data_len <= pkt_len;
               stored_len <= lq_head;
               idx        <= '0;
               state      <= WAIT_BUSY;
            end
            WAIT_BUSY: if (!i_ready) state <= STREAM;
            STREAM:    if (lq_pop) state <= DONE;
            DONE:      if (i_ready) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_payload_packer.sv
// tb/tb_udp_payload_packer.sv - self-checking bench for udp_payload_packer
module tb_udp_payload_packer;

`ifdef UDP_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int MAX_LEN = 1472;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] wr_data [2];
   logic       wr_en [2];
   logic       wr_last [2];
   logic       ready [2];
   logic       rd [2];
   logic       wr_ready [2];
   logic       drop [2];
   logic [3:0] pkt_cnt [2];
   logic       enable [2];
   logic [15:0] data_len [2];
   logic [7:0] rd_data [2];

   int total = 0;
   int bad = 0;
   int drop_seen = 0;
   int seg_cnt = 0;
   bit model_on = 1'b1;
   logic [7:0] exp_bytes [$];
   int exp_lens [$];

   typedef struct {
      int len;
      int base;
      int exp_cnt;
      int exp_first;
   } vec_t;
   vec_t tbl [8];

   always #5 clk = ~clk;

   udp_payload_packer #(.ADDR_W(11), .LQ_AW(3), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_wr_data(wr_data[0]), .i_wr_en(wr_en[0]), .i_wr_last(wr_last[0]),
      .o_wr_ready(wr_ready[0]), .o_drop(drop[0]), .o_pkt_cnt(pkt_cnt[0]),
      .i_ready(ready[0]), .o_enable(enable[0]), .o_data_len(data_len[0]),
      .i_rd(rd[0]), .o_rd_data(rd_data[0])
   );

   udp_payload_packer #(.ADDR_W(6), .LQ_AW(3), .MAX_LEN(MAX_LEN)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .i_wr_data(wr_data[1]), .i_wr_en(wr_en[1]), .i_wr_last(wr_last[1]),
      .o_wr_ready(wr_ready[1]), .o_drop(drop[1]), .o_pkt_cnt(pkt_cnt[1]),
      .i_ready(ready[1]), .o_enable(enable[1]), .o_data_len(data_len[1]),
      .i_rd(rd[1]), .o_rd_data(rd_data[1])
   );

   function automatic int pad_len(input int l);
      return (PAD && l < 18) ? 18 : l;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset(input int u);
      check("rst_enable", 32'(enable[u]), 0);
      check("rst_data_len", 32'(data_len[u]), 0);
      check("rst_rd_data", 32'(rd_data[u]), 0);
      check("rst_drop", 32'(drop[u]), 0);
      check("rst_pkt_cnt", 32'(pkt_cnt[u]), 0);
      check("rst_wr_ready", 32'(wr_ready[u]), 1);
   endtask

   task automatic drive_byte(input int u, input logic [7:0] d, input bit last);
      wr_en[u] = 1'b1;
      wr_data[u] = d;
      wr_last[u] = last;
      @(negedge clk);
      wr_en[u] = 1'b0;
      wr_last[u] = 1'b0;
      if (drop[u]) drop_seen++;
      if (model_on) begin
         exp_bytes.push_back(d);
         seg_cnt++;
         if (last || seg_cnt == MAX_LEN) begin
            exp_lens.push_back(seg_cnt);
            seg_cnt = 0;
         end
      end
   endtask

   task automatic write_pkt(input int u, input int len, input int base, input bit rnd);
      for (int i = 0; i < len; i++) begin
         if (rnd && $urandom_range(0, 4) == 0) @(negedge clk);
         drive_byte(u, rnd ? 8'($urandom) : 8'(base + i), i == len - 1);
      end
   endtask

   task automatic wait_en(input int u, output int cyc);
      cyc = 0;
      while (!enable[u] && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic take(input int u, input bit gaps);
      int l, dl, errs, k;
      logic [7:0] e;
      l = exp_lens.pop_front();
      dl = pad_len(l);
      check("data_len", 32'(data_len[u]), dl);
      ready[u] = 1'b0;
      @(negedge clk);
      check("enable_single", 32'(enable[u]), 0);
      errs = 0;
      k = 0;
      while (k < dl) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            rd[u] = 1'b0;
            @(negedge clk);
            continue;
         end
         e = (k < l) ? exp_bytes.pop_front() : 8'h00;
         if (rd_data[u] !== e) errs++;
         rd[u] = 1'b1;
         @(negedge clk);
         k++;
      end
      rd[u] = 1'b0;
      check("payload_bytes", errs, 0);
      ready[u] = 1'b1;
   endtask

   task automatic serve(input int u, input bit gaps);
      int cyc, l;
      ready[u] = 1'b1;
      wait_en(u, cyc);
      if (!enable[u]) begin
         check("enable_timeout", 0, 1);
         l = exp_lens.pop_front();
         repeat (l) void'(exp_bytes.pop_front());
         return;
      end
      take(u, gaps);
   endtask

   initial begin
      int cyc, n, errs, full_flag, en_cnt;
      for (int u = 0; u < 2; u++) begin
         wr_data[u] = '0; wr_en[u] = 1'b0; wr_last[u] = 1'b0;
         ready[u] = 1'b0; rd[u] = 1'b0;
      end
      tbl[0] = '{32,   8'h00, 1, 32};
      tbl[1] = '{5,    8'hA1, 1, PAD ? 18 : 5};
      tbl[2] = '{1500, 8'h10, 2, 1472};
      tbl[3] = '{1472, 8'h30, 1, 1472};
      tbl[4] = '{1473, 8'h55, 2, 1472};
      tbl[5] = '{18,   8'h77, 1, 18};
      tbl[6] = '{17,   8'h88, 1, PAD ? 18 : 17};
      tbl[7] = '{1,    8'hEE, 1, PAD ? 18 : 1};

      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      rst_n = 1'b1;
      @(negedge clk);

      // Enable latency with the framer already idle
      ready[0] = 1'b1;
      write_pkt(0, 32, 8'h40, 1'b0);
      check("lat_pkt_cnt", 32'(pkt_cnt[0]), 1);
      wait_en(0, cyc);
      check("enable_latency", cyc, 2);
      if (enable[0]) take(0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         ready[0] = 1'b0;
         write_pkt(0, tbl[t].len, tbl[t].base, 1'b0);
         check("tbl_pkt_cnt", 32'(pkt_cnt[0]), tbl[t].exp_cnt);
         ready[0] = 1'b1;
         wait_en(0, cyc);
         check("tbl_first_len", 32'(data_len[0]), tbl[t].exp_first);
         if (enable[0]) take(0, 1'b0);
         while (exp_lens.size() > 0) serve(0, 1'b0);
      end

      // Three queued packets; stray i_rd while idle must be ignored
      ready[0] = 1'b0;
      write_pkt(0, 4, 8'h01, 1'b0);
      write_pkt(0, 20, 8'h20, 1'b0);
      write_pkt(0, 9, 8'h90, 1'b0);
      check("three_pkt_cnt", 32'(pkt_cnt[0]), 3);
      rd[0] = 1'b1;
      repeat (3) @(negedge clk);
      rd[0] = 1'b0;
      en_cnt = 0;
      while (exp_lens.size() > 0) begin
         serve(0, 1'b0);
         en_cnt++;
      end
      check("three_enables", en_cnt, 3);

      // Commit and pop on the same edge
      ready[0] = 1'b0;
      write_pkt(0, 3, 8'hC0, 1'b0);
      drive_byte(0, 8'hD0, 1'b0);
      drive_byte(0, 8'hD1, 1'b0);
      drive_byte(0, 8'hD2, 1'b0);
      check("cp_pkt_cnt_pre", 32'(pkt_cnt[0]), 1);
      ready[0] = 1'b1;
      wait_en(0, cyc);
      check("cp_len", 32'(data_len[0]), pad_len(exp_lens.pop_front()));
      ready[0] = 1'b0;
      @(negedge clk);
      errs = 0;
      for (int k = 0; k < pad_len(3); k++) begin
         if (rd_data[0] !== ((k < 3) ? exp_bytes.pop_front() : 8'h00)) errs++;
         rd[0] = 1'b1;
         if (k == pad_len(3) - 1) drive_byte(0, 8'hD3, 1'b1);
         else @(negedge clk);
      end
      rd[0] = 1'b0;
      check("cp_bytes", errs, 0);
      check("cp_pkt_cnt_post", 32'(pkt_cnt[0]), 1);
      serve(0, 1'b0);

      // Randomized batches checked against the queue model
      for (int b = 0; b < 6; b++) begin
         ready[0] = 1'b0;
         n = $urandom_range(1, 6);
         for (int p = 0; p < n; p++) write_pkt(0, $urandom_range(1, 250), 0, 1'b1);
         check("rand_pkt_cnt", 32'(pkt_cnt[0]), exp_lens.size());
         while (exp_lens.size() > 0) serve(0, 1'b1);
      end

      // RAM overflow on the 64-byte instance
      ready[1] = 1'b0;
      model_on = 1'b0;
      drop_seen = 0;
      full_flag = 1;
      for (int i = 0; i < 70; i++) begin
         drive_byte(1, 8'(i), i == 69);
         if (i == 63) full_flag = 32'(wr_ready[1]);
      end
      check("ovf_ready_low", full_flag, 0);
      check("ovf_drop_once", drop_seen, 1);
      check("ovf_pkt_cnt", 32'(pkt_cnt[1]), 0);
      check("ovf_ready_back", 32'(wr_ready[1]), 1);
      model_on = 1'b1;
      seg_cnt = 0;
      write_pkt(1, 10, 8'hB0, 1'b0);
      check("ovf_next_cnt", 32'(pkt_cnt[1]), 1);
      serve(1, 1'b0);

      // Reset in the middle of streaming
      ready[0] = 1'b0;
      write_pkt(0, 40, 8'h60, 1'b0);
      ready[0] = 1'b1;
      wait_en(0, cyc);
      ready[0] = 1'b0;
      @(negedge clk);
      rd[0] = 1'b1;
      repeat (10) @(negedge clk);
      rd[0] = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset(0);
      rst_n = 1'b1;
      ready[0] = 1'b1;
      en_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (enable[0]) en_cnt++;
      end
      check("post_reset_enable", en_cnt, 0);
      exp_bytes.delete();
      exp_lens.delete();
      seg_cnt = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
